// File: rtl/calculator_pkg.sv
// Shared calculator types plus the arbitration state and limits used by
// calc_arbiter and other blocks that share one calculator datapath.
package calculator_pkg;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR
  } te_operation;

  typedef enum logic [1:0] {
    STATUS_OK,
    STATUS_OVERFLOW,
    STATUS_UNDERFLOW,
    STATUS_ERROR
  } te_out_status;

  localparam int CALC_ARB_MAX_REQ = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RESP
  } te_arb_state;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Reusable by any block that shares one resource among NUM_REQ clients.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin sharing of one calculator datapath among NUM_REQ requesters.
// Optional per-requester grant counters are enabled by CALC_ARB_PERF_EN.
module calc_arbiter
  import calculator_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_REQ    = 4,
  parameter int DP_LATENCY = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]          req_a,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]          req_b,
  input  logic [NUM_REQ*$bits(te_operation)-1:0] req_op,
  output logic [BIT_WIDTH-1:0]                  dp_a,
  output logic [BIT_WIDTH-1:0]                  dp_b,
  output te_operation                           dp_operation,
  input  logic [BIT_WIDTH-1:0]                  dp_result,
  input  te_out_status                          dp_status,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]            rsp_id,
  output logic [BIT_WIDTH-1:0]                  rsp_result,
  output te_out_status                          rsp_status,
`ifdef CALC_ARB_PERF_EN
  output logic [NUM_REQ*16-1:0]                 grant_count,
`endif
  output logic                                  busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int OP_W  = $bits(te_operation);
  // EXEC always lasts at least one cycle so the registered operands reach the datapath.
  localparam logic [3:0] LAT_LAST = (DP_LATENCY == 0) ? 4'd0 : 4'(DP_LATENCY - 1);

  te_arb_state            state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0]   dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  te_operation            dp_op_q, dp_op_d;
  logic [IDX_W-1:0]       rsp_id_q, rsp_id_d;
  logic [BIT_WIDTH-1:0]   rsp_result_q, rsp_result_d;
  te_out_status           rsp_status_q, rsp_status_d;
  logic [NUM_REQ-1:0]     req_ready_c;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_op_d      = dp_op_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;
    req_ready_c  = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          req_ready_c = pick_grant;
          dp_a_d      = req_a[int'(pick_idx)*BIT_WIDTH +: BIT_WIDTH];
          dp_b_d      = req_b[int'(pick_idx)*BIT_WIDTH +: BIT_WIDTH];
          dp_op_d     = te_operation'(req_op[int'(pick_idx)*OP_W +: OP_W]);
          rsp_id_d    = pick_idx;
          rr_ptr_d    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          cnt_d       = 4'd0;
          state_d     = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        if (cnt_q == LAT_LAST) begin
          rsp_result_d = dp_result;
          rsp_status_d = dp_status;
          state_d      = ARB_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ARB_RESP: begin
        if (rsp_ready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_op_q      <= OP_ADD;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_status_q <= STATUS_OK;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_op_q      <= dp_op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // The grant is combinational, so mask it while reset is held.
  assign req_ready    = reset ? '0 : req_ready_c;
  assign dp_a         = dp_a_q;
  assign dp_b         = dp_b_q;
  assign dp_operation = dp_op_q;
  assign rsp_valid    = (state_q == ARB_RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_status   = rsp_status_q;
  assign busy         = (state_q != ARB_IDLE);

`ifdef CALC_ARB_PERF_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [15:0] gc_q, gc_d;
    always_comb begin
      gc_d = gc_q;
      if (req_ready_c[gi] && (gc_q != 16'hFFFF)) gc_d = gc_q + 16'd1;
    end
    always_ff @(posedge clk) begin
      if (reset) gc_q <= '0;
      else       gc_q <= gc_d;
    end
    assign grant_count[gi*16 +: 16] = gc_q;
  end
`endif

endmodule
